// File: rtl/axi4_lite_csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR slave: register offsets, response codes
// and the channel FSM state types.
package axi4_lite_csr_pkg;

   localparam logic [7:0] CSR_CTRL       = 8'h00;
   localparam logic [7:0] CSR_STATUS     = 8'h04;
   localparam logic [7:0] CSR_IRQ_STATUS = 8'h08;
   localparam logic [7:0] CSR_SCRATCH    = 8'h0C;
   localparam logic [7:0] CSR_VERSION    = 8'h10;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

endpackage

// File: rtl/axi4_lite_csr_slave_if.sv
// AXI4-Lite bus bundle between the GP master and the CSR slave.
interface axi4_lite_csr_slave_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;

   modport slave (
      input  s_awaddr, s_awvalid,
      output s_awready,
      input  s_wdata, s_wstrb, s_wvalid,
      output s_wready,
      output s_bresp, s_bvalid,
      input  s_bready,
      input  s_araddr, s_arvalid,
      output s_arready,
      output s_rdata, s_rresp, s_rvalid,
      input  s_rready
   );

   modport master (
      output s_awaddr, s_awvalid,
      input  s_awready,
      output s_wdata, s_wstrb, s_wvalid,
      input  s_wready,
      input  s_bresp, s_bvalid,
      output s_bready,
      output s_araddr, s_arvalid,
      input  s_arready,
      input  s_rdata, s_rresp, s_rvalid,
      output s_rready
   );
endinterface

// File: rtl/axi4_lite_csr_regbank.sv
// CSR storage: CTRL/SCRATCH with byte strobes, W1C IRQ_STATUS with set pulses,
// read mux and per-access decode-error flags.
module axi4_lite_csr_regbank
   import axi4_lite_csr_pkg::*;
#(
   parameter int          ADDR_W  = 12,
   parameter logic [31:0] VERSION = 32'h0001_0000,
   parameter int          IRQ_W   = 8
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [31:0]       i_wrData,
   input  logic [3:0]        i_wrStrb,
   output logic              o_wrErr,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [31:0]       o_rdData,
   output logic              o_rdErr,
   input  logic [31:0]       i_status,
   input  logic [IRQ_W-1:0]  i_irqSet,
   output logic [31:0]       o_ctrl,
   output logic              o_irq
);

   logic [31:0]       r_ctrl;
   logic [31:0]       r_scratch;
   logic [IRQ_W-1:0]  r_irqStatus;
   logic              r_irqOut;

   logic [ADDR_W-1:0] w_wrWord;
   logic [ADDR_W-1:0] w_rdWord;
   logic [31:0]       w_byteMask;
   logic [31:0]       w_wrMasked;
   logic              w_selCtrl;
   logic              w_selIrq;
   logic              w_selScratch;
   logic [IRQ_W-1:0]  w_irqClr;

   assign w_wrWord     = i_wrAddr & ~ADDR_W'(3);
   assign w_rdWord     = i_rdAddr & ~ADDR_W'(3);
   assign w_selCtrl    = (w_wrWord == ADDR_W'(CSR_CTRL));
   assign w_selIrq     = (w_wrWord == ADDR_W'(CSR_IRQ_STATUS));
   assign w_selScratch = (w_wrWord == ADDR_W'(CSR_SCRATCH));
   assign o_wrErr      = !(w_selCtrl || w_selIrq || w_selScratch);

   always_comb begin
      w_byteMask = '0;
      for (int i = 0; i < 4; i++) begin
         w_byteMask[i*8 +: 8] = {8{i_wrStrb[i]}};
      end
   end

   assign w_wrMasked = i_wrData & w_byteMask;
   assign w_irqClr   = (i_wrEn && w_selIrq) ? w_wrMasked[IRQ_W-1:0] : '0;

   // Set pulses are OR-ed in after the clear so a simultaneous set wins.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ctrl      <= '0;
         r_scratch   <= '0;
         r_irqStatus <= '0;
         r_irqOut    <= 1'b0;
      end else begin
         if (i_wrEn && w_selCtrl) begin
            r_ctrl <= (r_ctrl & ~w_byteMask) | w_wrMasked;
         end
         if (i_wrEn && w_selScratch) begin
            r_scratch <= (r_scratch & ~w_byteMask) | w_wrMasked;
         end
         r_irqStatus <= (r_irqStatus & ~w_irqClr) | i_irqSet;
         r_irqOut    <= |r_irqStatus;
      end
   end

   always_comb begin
      o_rdData = '0;
      o_rdErr  = 1'b0;
      case (w_rdWord)
         ADDR_W'(CSR_CTRL):       o_rdData = r_ctrl;
         ADDR_W'(CSR_STATUS):     o_rdData = i_status;
         ADDR_W'(CSR_IRQ_STATUS): o_rdData[IRQ_W-1:0] = r_irqStatus;
         ADDR_W'(CSR_SCRATCH):    o_rdData = r_scratch;
         ADDR_W'(CSR_VERSION):    o_rdData = VERSION;
         default:                 o_rdErr  = 1'b1;
      endcase
   end

   assign o_ctrl = r_ctrl;
   assign o_irq  = r_irqOut;

endmodule

// File: rtl/axi4_lite_csr_slave.sv
// AXI4-Lite CSR slave top: independent write (AW/W/B) and read (AR/R) channel FSMs
// in front of the register bank.
module axi4_lite_csr_slave
   import axi4_lite_csr_pkg::*;
#(
   parameter int          ADDR_W  = 12,
   parameter int          DATA_W  = 32,
   parameter logic [31:0] VERSION = 32'h0001_0000,
   parameter int          IRQ_W   = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axi4_lite_csr_slave_if.slave  s_axi,
   output logic [31:0]           ctrl_o,
   input  logic [31:0]           status_i,
   input  logic [IRQ_W-1:0]      irq_set_i,
   output logic                  irq_o
);

   if (DATA_W != 32) begin : g_badDataWidth
      $error("axi4_lite_csr_slave supports DATA_W = 32 only");
   end

   wstate_t           r_wState, w_wStateNext;
   logic              r_awReady, w_awReadyNext;
   logic              r_wReady, w_wReadyNext;
   logic              r_awHeld, r_wHeld;
   logic [ADDR_W-1:0] r_awAddr;
   logic [31:0]       r_wData;
   logic [3:0]        r_wStrb;
   resp_t             r_bResp;

   rstate_t           r_rState, w_rStateNext;
   logic              r_arReady, w_arReadyNext;
   logic [31:0]       r_rData;
   resp_t             r_rResp;

   logic              w_awHs, w_wHs, w_arHs;
   logic              w_haveAw, w_haveW, w_commit;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [31:0]       w_wrData;
   logic [3:0]        w_wrStrb;
   logic              w_wrErr;
   logic [31:0]       w_rdData;
   logic              w_rdErr;

   assign w_awHs   = s_axi.s_awvalid && r_awReady;
   assign w_wHs    = s_axi.s_wvalid && r_wReady;
   assign w_arHs   = s_axi.s_arvalid && r_arReady;
   assign w_haveAw = r_awHeld || w_awHs;
   assign w_haveW  = r_wHeld || w_wHs;
   assign w_commit = (r_wState == W_IDLE) && w_haveAw && w_haveW;
   assign w_wrAddr = r_awHeld ? r_awAddr : s_axi.s_awaddr;
   assign w_wrData = r_wHeld  ? r_wData  : s_axi.s_wdata;
   assign w_wrStrb = r_wHeld  ? r_wStrb  : s_axi.s_wstrb;

   // Ready flags are registered so they read 0 while reset is held.
   always_comb begin
      w_wStateNext  = r_wState;
      w_awReadyNext = 1'b0;
      w_wReadyNext  = 1'b0;
      case (r_wState)
         W_IDLE: begin
            if (w_commit) begin
               w_wStateNext = W_RESP;
            end else begin
               w_awReadyNext = !w_haveAw;
               w_wReadyNext  = !w_haveW;
            end
         end
         W_RESP: begin
            if (s_axi.s_bready) begin
               w_wStateNext  = W_IDLE;
               w_awReadyNext = 1'b1;
               w_wReadyNext  = 1'b1;
            end
         end
         default: w_wStateNext = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wState  <= W_IDLE;
         r_awReady <= 1'b0;
         r_wReady  <= 1'b0;
         r_awHeld  <= 1'b0;
         r_wHeld   <= 1'b0;
         r_awAddr  <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
         r_bResp   <= OKAY;
      end else begin
         r_wState  <= w_wStateNext;
         r_awReady <= w_awReadyNext;
         r_wReady  <= w_wReadyNext;
         if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bResp  <= w_wrErr ? SLVERR : OKAY;
         end else begin
            if (w_awHs) begin
               r_awHeld <= 1'b1;
               r_awAddr <= s_axi.s_awaddr;
            end
            if (w_wHs) begin
               r_wHeld <= 1'b1;
               r_wData <= s_axi.s_wdata;
               r_wStrb <= s_axi.s_wstrb;
            end
         end
      end
   end

   always_comb begin
      w_rStateNext  = r_rState;
      w_arReadyNext = 1'b0;
      case (r_rState)
         R_IDLE: begin
            if (w_arHs) begin
               w_rStateNext = R_DATA;
            end else begin
               w_arReadyNext = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi.s_rready) begin
               w_rStateNext  = R_IDLE;
               w_arReadyNext = 1'b1;
            end
         end
         default: w_rStateNext = R_IDLE;
      endcase
   end

   // Read data is captured at the AR handshake edge, so it sees pre-write values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rState  <= R_IDLE;
         r_arReady <= 1'b0;
         r_rData   <= '0;
         r_rResp   <= OKAY;
      end else begin
         r_rState  <= w_rStateNext;
         r_arReady <= w_arReadyNext;
         if (w_arHs) begin
            r_rData <= w_rdData;
            r_rResp <= w_rdErr ? SLVERR : OKAY;
         end
      end
   end

   axi4_lite_csr_regbank #(
      .ADDR_W  (ADDR_W),
      .VERSION (VERSION),
      .IRQ_W   (IRQ_W)
   ) u_regbank (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .i_wrEn   (w_commit),
      .i_wrAddr (w_wrAddr),
      .i_wrData (w_wrData),
      .i_wrStrb (w_wrStrb),
      .o_wrErr  (w_wrErr),
      .i_rdAddr (s_axi.s_araddr),
      .o_rdData (w_rdData),
      .o_rdErr  (w_rdErr),
      .i_status (status_i),
      .i_irqSet (irq_set_i),
      .o_ctrl   (ctrl_o),
      .o_irq    (irq_o)
   );

   assign s_axi.s_awready = r_awReady;
   assign s_axi.s_wready  = r_wReady;
   assign s_axi.s_bvalid  = (r_wState == W_RESP);
   assign s_axi.s_bresp   = r_bResp;
   assign s_axi.s_arready = r_arReady;
   assign s_axi.s_rvalid  = (r_rState == R_DATA);
   assign s_axi.s_rdata   = r_rData;
   assign s_axi.s_rresp   = r_rResp;

endmodule
